// File: rtl/encoder_8to3_pending.sv
// Sequential 8-to-3 priority encoder with pending register and valid/ready output.
// Define ENC_OVERFLOW_EN to add the sticky lost-duplicate-request flag.
module encoder_8to3_pending #(
    parameter int PRIORITY_HIGH = 1,
    parameter int REQ_EDGE      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] y_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] code,
    output logic       any_pending,
    output logic       multi
`ifdef ENC_OVERFLOW_EN
    ,
    output logic       overflow
`endif
);

    localparam logic S_IDLE    = 1'b0;
    localparam logic S_PRESENT = 1'b1;

    logic       state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] prev_q;
    logic       any_q, multi_q;
    logic [7:0] req;
    logic [7:0] clr;
    logic [7:0] rest;
    logic       fire;

    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (PRIORITY_HIGH != 0) begin
                if (v[i]) idx = 3'(i);
            end else begin
                if (v[7-i]) idx = 3'(7 - i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        req = 8'h00;
        if (en) begin
            if (REQ_EDGE != 0) req = y_in & ~prev_q;
            else               req = y_in;
        end
    end

    assign fire = (state_q == S_PRESENT) && en && out_ready;

    // Set beats clear: req is ORed in after the serviced bit is dropped.
    always_comb begin
        clr    = fire ? (8'h01 << code_q) : 8'h00;
        rest   = pend_q & ~clr;
        pend_d = rest | req;
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (en) begin
            if (state_q == S_IDLE) begin
                if (pend_q != 8'h00) begin
                    state_d = S_PRESENT;
                    code_d  = prio_idx(pend_q);
                end
            end else if (out_ready) begin
                if (rest != 8'h00) code_d  = prio_idx(rest);
                else               state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= 3'd0;
            pend_q  <= 8'h00;
            prev_q  <= 8'h00;
            any_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            prev_q  <= y_in;
            any_q   <= pend_d != 8'h00;
            multi_q <= (pend_d & (pend_d - 8'd1)) != 8'h00;
        end
    end

`ifdef ENC_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else if ((req & rest) != 8'h00) ovf_q <= 1'b1;
    end

    assign overflow = ovf_q;
`endif

    assign out_valid   = (state_q == S_PRESENT) && en;
    assign code        = code_q;
    assign any_pending = any_q;
    assign multi       = multi_q;

endmodule

// File: tb/tb_encoder_8to3_pending.sv
// Bench for encoder_8to3_pending: directed scenarios plus random traffic
// on two instances (high-priority/level and low-priority/edge).
module tb_encoder_8to3_pending;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic [7:0] yi [2];
    logic       ry [2];
    logic       ov [2];
    logic [2:0] oc [2];
    logic       oa [2];
    logic       om [2];
`ifdef ENC_OVERFLOW_EN
    logic       of [2];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    encoder_8to3_pending #(.PRIORITY_HIGH(1), .REQ_EDGE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .y_in(yi[0]), .out_ready(ry[0]),
        .out_valid(ov[0]), .code(oc[0]), .any_pending(oa[0]), .multi(om[0])
`ifdef ENC_OVERFLOW_EN
        , .overflow(of[0])
`endif
    );

    encoder_8to3_pending #(.PRIORITY_HIGH(0), .REQ_EDGE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .y_in(yi[1]), .out_ready(ry[1]),
        .out_valid(ov[1]), .code(oc[1]), .any_pending(oa[1]), .multi(om[1])
`ifdef ENC_OVERFLOW_EN
        , .overflow(of[1])
`endif
    );

    // Reference model: a set of pending lines and one presented code.
    bit [7:0] mp [2];
    bit [7:0] mprev [2];
    bit       mst [2];
    int       mc [2];
    bit       movf [2];

    function automatic int pick(input logic [7:0] v, input bit hi);
        int p;
        p = -1;
        for (int i = 0; i < 8; i++) begin
            if (hi) begin
                if (v[7-i] && p < 0) p = 7 - i;
            end else begin
                if (v[i] && p < 0) p = i;
            end
        end
        return p;
    endfunction

    task automatic mstep(input int k, input bit hi, input bit edg,
                         input logic [7:0] y, input logic e, input logic r);
        logic [7:0] nreq, served, left;
        nreq = 8'h00;
        served = 8'h00;
        if (e) nreq = edg ? (y & ~mprev[k]) : y;
        mprev[k] = y;
        if (mst[k] && e && r) served[mc[k]] = 1'b1;
        left = mp[k] & ~served;
        if ((nreq & left) != 0) movf[k] = 1'b1;
        if (e) begin
            if (!mst[k]) begin
                if (mp[k] != 0) begin
                    mst[k] = 1'b1;
                    mc[k] = pick(mp[k], hi);
                end
            end else if (r) begin
                if (left != 0) mc[k] = pick(left, hi);
                else mst[k] = 1'b0;
            end
        end
        mp[k] = left | nreq;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mp[k] = 0; mprev[k] = 0; mst[k] = 0; mc[k] = 0; movf[k] = 0;
            end
        end else begin
            mstep(0, 1'b1, 1'b0, yi[0], en, ry[0]);
            mstep(1, 1'b0, 1'b1, yi[1], en, ry[1]);
        end
    end

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ov[k] !== 1'b0) begin bad++; $display("FAIL rst_valid%0d got=%0h want=0", k, ov[k]); end
            total++;
            if (oc[k] !== 3'd0) begin bad++; $display("FAIL rst_code%0d got=%0h want=0", k, oc[k]); end
            total++;
            if (oa[k] !== 1'b0) begin bad++; $display("FAIL rst_any%0d got=%0h want=0", k, oa[k]); end
            total++;
            if (om[k] !== 1'b0) begin bad++; $display("FAIL rst_multi%0d got=%0h want=0", k, om[k]); end
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        seen = 0;
        ry[0] = 1'b0;
        yi[0] = 8'h10;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ov[0]) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rstmid_wait got=0 want=1"); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0h want=0", ov[0]); end
        total++;
        if (oc[0] !== 3'd0) begin bad++; $display("FAIL rstmid_code got=%0h want=0", oc[0]); end
        total++;
        if (oa[0] !== 1'b0) begin bad++; $display("FAIL rstmid_any got=%0h want=0", oa[0]); end
        total++;
        if (om[0] !== 1'b0) begin bad++; $display("FAIL rstmid_multi got=%0h want=0", om[0]); end
        yi[0] = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL rstmid_empty_v got=%0h want=0", ov[0]); end
        total++;
        if (oa[0] !== 1'b0) begin bad++; $display("FAIL rstmid_empty_a got=%0h want=0", oa[0]); end
    endtask

    task automatic test_single;
        int cnt;
        cnt = 0;
        ry[0] = 1'b1;
        @(negedge clk);
        yi[0] = 8'h20;
        @(negedge clk);
        yi[0] = 8'h00;
        total++;
        if (oa[0] !== 1'b1) begin bad++; $display("FAIL single_any_set got=%0h want=1", oa[0]); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov[0]) begin
                cnt++;
                total++;
                if (oc[0] !== 3'd5) begin bad++; $display("FAIL single_code got=%0d want=5", oc[0]); end
            end
        end
        total++;
        if (cnt != 1) begin bad++; $display("FAIL single_count got=%0d want=1", cnt); end
        total++;
        if (oa[0] !== 1'b0) begin bad++; $display("FAIL single_any_clr got=%0h want=0", oa[0]); end
    endtask

    task automatic test_back_to_back;
        ry[0] = 1'b1;
        @(negedge clk);
        yi[0] = 8'h81;
        @(negedge clk);
        yi[0] = 8'h00;
        total++;
        if (om[0] !== 1'b1) begin bad++; $display("FAIL b2b_multi0 got=%0h want=1", om[0]); end
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL b2b_valid0 got=%0h want=0", ov[0]); end
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b1 || oc[0] !== 3'd7) begin
            bad++; $display("FAIL b2b_first got=%0h/%0d want=1/7", ov[0], oc[0]);
        end
        total++;
        if (om[0] !== 1'b1) begin bad++; $display("FAIL b2b_multi1 got=%0h want=1", om[0]); end
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b1 || oc[0] !== 3'd0) begin
            bad++; $display("FAIL b2b_second got=%0h/%0d want=1/0", ov[0], oc[0]);
        end
        total++;
        if (om[0] !== 1'b0) begin bad++; $display("FAIL b2b_multi2 got=%0h want=0", om[0]); end
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0 || oa[0] !== 1'b0) begin
            bad++; $display("FAIL b2b_idle got=%0h/%0h want=0/0", ov[0], oa[0]);
        end
    endtask

    task automatic test_backpressure;
        ry[0] = 1'b0;
        @(negedge clk);
        yi[0] = 8'h04;
        @(negedge clk);
        yi[0] = 8'h00;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            total++;
            if (ov[0] !== 1'b1 || oc[0] !== 3'd2) begin
                bad++; $display("FAIL stall_hold%0d got=%0h/%0d want=1/2", s, ov[0], oc[0]);
            end
            yi[0] = (s == 1) ? 8'h40 : 8'h00;
        end
        ry[0] = 1'b1;
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b1 || oc[0] !== 3'd6) begin
            bad++; $display("FAIL stall_next got=%0h/%0d want=1/6", ov[0], oc[0]);
        end
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL stall_idle got=%0h want=0", ov[0]); end
    endtask

    task automatic test_sweep;
        logic [7:0] oh;
        logic [7:0] dec;
        bit seen;
        en = 1'b1;
        ry[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            oh = 8'h01 << i;
            @(negedge clk);
            yi[0] = oh;
            @(negedge clk);
            yi[0] = 8'h00;
            seen = 0;
            dec = 8'h00;
            for (int w = 0; w < 5 && !seen; w++) begin
                @(negedge clk);
                if (ov[0]) begin seen = 1; dec = 8'h01 << oc[0]; end
            end
            total++;
            if (dec !== oh) begin bad++; $display("FAIL sweep_dec%0d got=%0h want=%0h", i, dec, oh); end
            @(negedge clk);
        end
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            oh = 8'h01 << i;
            yi[0] = oh;
            @(negedge clk);
            yi[0] = 8'h00;
            repeat (2) @(negedge clk);
            total++;
            if (ov[0] !== 1'b0 || oa[0] !== 1'b0) begin
                bad++; $display("FAIL sweep_off%0d got=%0h/%0h want=0/0", i, ov[0], oa[0]);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_en_hold;
        ry[0] = 1'b0;
        @(negedge clk);
        yi[0] = 8'h02;
        @(negedge clk);
        yi[0] = 8'h00;
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b1 || oc[0] !== 3'd1) begin
            bad++; $display("FAIL enh_pres got=%0h/%0d want=1/1", ov[0], oc[0]);
        end
        en = 1'b0;
        ry[0] = 1'b1;
        #1;
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL enh_mask got=%0h want=0", ov[0]); end
        repeat (2) @(negedge clk);
        total++;
        if (oa[0] !== 1'b1) begin bad++; $display("FAIL enh_keep got=%0h want=1", oa[0]); end
        en = 1'b1;
        #1;
        total++;
        if (ov[0] !== 1'b1 || oc[0] !== 3'd1) begin
            bad++; $display("FAIL enh_resume got=%0h/%0d want=1/1", ov[0], oc[0]);
        end
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0 || oa[0] !== 1'b0) begin
            bad++; $display("FAIL enh_done got=%0h/%0h want=0/0", ov[0], oa[0]);
        end
    endtask

    task automatic test_edge_mode;
        int cnt;
        cnt = 0;
        ry[1] = 1'b1;
        @(negedge clk);
        yi[1] = 8'h08;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (ov[1]) begin
                cnt++;
                total++;
                if (oc[1] !== 3'd3) begin bad++; $display("FAIL edge_code got=%0d want=3", oc[1]); end
            end
            yi[1] = (t < 3) ? 8'h08 : 8'h00;
        end
        total++;
        if (cnt != 1) begin bad++; $display("FAIL edge_count got=%0d want=1", cnt); end
        @(negedge clk);
        yi[1] = 8'h81;
        @(negedge clk);
        yi[1] = 8'h00;
        @(negedge clk);
        total++;
        if (ov[1] !== 1'b1 || oc[1] !== 3'd0) begin
            bad++; $display("FAIL lowpri_first got=%0h/%0d want=1/0", ov[1], oc[1]);
        end
        @(negedge clk);
        total++;
        if (ov[1] !== 1'b1 || oc[1] !== 3'd7) begin
            bad++; $display("FAIL lowpri_second got=%0h/%0d want=1/7", ov[1], oc[1]);
        end
        @(negedge clk);
`ifdef ENC_OVERFLOW_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (of[1] !== 1'b0) begin bad++; $display("FAIL ovf_init got=%0h want=0", of[1]); end
        ry[1] = 1'b0;
        yi[1] = 8'h08;
        @(negedge clk);
        yi[1] = 8'h00;
        @(negedge clk);
        yi[1] = 8'h08;
        @(negedge clk);
        yi[1] = 8'h00;
        total++;
        if (of[1] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h want=1", of[1]); end
        repeat (3) @(negedge clk);
        total++;
        if (of[1] !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h want=1", of[1]); end
        rst = 1'b1;
        #1;
        total++;
        if (of[1] !== 1'b0) begin bad++; $display("FAIL ovf_rst got=%0h want=0", of[1]); end
        @(negedge clk);
        rst = 1'b0;
        ry[1] = 1'b1;
`endif
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ov[k] !== (mst[k] && en)) begin
                    bad++; $display("FAIL rnd_valid%0d c=%0d got=%0h want=%0h", k, c, ov[k], mst[k] && en);
                end
                total++;
                if (oc[k] !== 3'(mc[k])) begin
                    bad++; $display("FAIL rnd_code%0d c=%0d got=%0d want=%0d", k, c, oc[k], mc[k]);
                end
                total++;
                if (oa[k] !== (mp[k] != 0)) begin
                    bad++; $display("FAIL rnd_any%0d c=%0d got=%0h want=%0h", k, c, oa[k], mp[k] != 0);
                end
                total++;
                if (om[k] !== ($countones(mp[k]) > 1)) begin
                    bad++; $display("FAIL rnd_multi%0d c=%0d got=%0h want=%0h", k, c, om[k], $countones(mp[k]) > 1);
                end
`ifdef ENC_OVERFLOW_EN
                total++;
                if (of[k] !== movf[k]) begin
                    bad++; $display("FAIL rnd_ovf%0d c=%0d got=%0h want=%0h", k, c, of[k], movf[k]);
                end
`endif
            end
            en = ($urandom_range(0, 9) < 8);
            for (int k = 0; k < 2; k++) begin
                yi[k] = 8'($urandom) & 8'($urandom) & 8'($urandom);
                ry[k] = ($urandom_range(0, 3) != 0);
            end
        end
        en = 1'b1;
        yi[0] = 8'h00;
        yi[1] = 8'h00;
    endtask

    initial begin
        yi[0] = 8'h00; yi[1] = 8'h00;
        ry[0] = 1'b0; ry[1] = 1'b0;
        #1 rst = 1'b1;
        #11;
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        test_reset_mid;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_sweep;
        test_en_hold;
        test_edge_mode;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_8to3_pending.md
Name: encoder_8to3_pending

Overview:
- Sequential 8-to-3 priority encoder; the inverse of the team's 3-to-8 decoder.
- Captures requests on eight one-hot-style lines into a pending register.
- Presents the highest-priority pending line as a 3-bit binary code over a valid/ready handshake, and clears each line once it is serviced.
- Sits between request sources and a consumer that regenerates one-hot selects through the decoder, enabling round-trip decode/encode checks.

Parameters:
- PRIORITY_HIGH, 1, 1 = line 7 has highest priority; 0 = line 0 has highest priority.
- REQ_EDGE, 0, 0 = level capture (a high line sets its pending bit every enabled cycle); 1 = rising-edge capture (set only on a 0->1 transition vs. the previous sampled value).

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture/present enable, same sense as the decoder enable.
- y_in  input  8  request lines; bit i = line Yi.
- out_ready  input  1  consumer accepts the code this cycle.
- out_valid  output  1  code holds a pending line.
- code  output  3  binary index of the presented line.
- any_pending  output  1  OR of the pending register (registered).
- multi  output  1  more than one pending bit set (registered).

Behaviour:
- Reset (async, active-high):
  - pending = 8'h00, prev_y = 8'h00.
  - out_valid = 0, code = 3'b000, any_pending = 0, multi = 0.
  - Takes effect immediately mid-transfer; any presented code is dropped without handshake.
- Capture, per rising clk edge with en = 1:
  - req = y_in when REQ_EDGE = 0; req = y_in & ~prev_y when REQ_EDGE = 1.
  - prev_y <= y_in on every edge, regardless of en.
- Pending update: pending <= (pending & ~clr) | req.
  - clr is the one-hot of code when out_valid && out_ready, otherwise 0.
  - If set and clear hit the same bit in one cycle, set wins and the bit stays pending.
- Output register, two states:
  - IDLE (out_valid = 0): on an edge with en = 1 and pending != 0, load code = priority index of pending (prior value, not including this edge's req) and go to PRESENT.
  - PRESENT (out_valid = 1): code and out_valid stay stable while out_ready = 0. No re-arbitration, even if a higher-priority line arrives.
  - PRESENT with out_ready = 1 at an edge: transfer completes.
    - If (pending & ~clr) != 0, load the next priority index and stay in PRESENT (back-to-back, one code per cycle).
    - Otherwise go to IDLE.
- Latency: a request sampled at edge N reaches pending at N; out_valid = 1 with its code at edge N+1, provided the block was IDLE or it wins at the next handshake.
- en = 0:
  - No capture; pending is retained.
  - IDLE does not advance to PRESENT.
  - In PRESENT, out_valid is forced low combinationally and the handshake is blocked (no clear). State and code are held, and resume when en returns to 1.
- any_pending and multi are registered from the next-state pending value, so they are updated on the same edge as pending.
- code is a 3-bit unsigned index. With PRIORITY_HIGH = 1, pending 8'b1000_0001 gives code 7; with PRIORITY_HIGH = 0 it gives code 0.

Optional Feature:
- Macro: ENC_OVERFLOW_EN.
- When defined:
  - Adds output `overflow` (1 bit, sticky, reset 0).
  - `overflow` is set on any edge where req[i] = 1 while pending[i] = 1 and bit i is not being cleared in the same cycle (a lost duplicate request).
  - Cleared only by rst.
- When undefined: the port and logic are absent, and duplicate requests merge silently.

Test Plan:
- Reset mid-PRESENT: hold y_in = 8'h10 until out_valid = 1, assert rst asynchronously between edges -> out_valid, code, any_pending and multi read 0 immediately; pending is empty after rst deasserts.
- Single line, level mode: en = 1, y_in = 8'h20 for one cycle, out_ready = 1 -> out_valid high for exactly one cycle with code = 5; then IDLE, any_pending = 0.
- Priority and back-to-back: y_in = 8'h81 pulsed once, out_ready = 1, PRIORITY_HIGH = 1 -> codes 7 then 0 on consecutive cycles; multi = 1 before the first transfer and 0 after it.
- Backpressure stability: y_in = 8'h04 pulse, out_ready = 0 for 5 cycles, y_in = 8'h40 pulsed during the stall -> code holds 2 throughout the stall; release out_ready -> codes 2, then 6.
- en gating, all-input sweep: walk each one-hot y_in (8'h01 to 8'h80) and drive the code into decoder_3to8 with en = 1 -> the decoder reproduces the same one-hot. Repeat with en = 0 -> out_valid stays 0 and no capture occurs.
- Edge mode with ENC_OVERFLOW_EN defined (REQ_EDGE = 1): hold y_in = 8'h08 high for 4 cycles -> exactly one code 3 transfer. Stall out_ready = 0 and toggle bit 3 low then high -> overflow = 1 and stays 1 until rst.
